cpu_ctrl: RTL and testbench
===========================

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The block SHALL be a controller FSM plus instruction register, driving the control port of the team's register-file/ALU datapath.
REQ-002 Parameters: none; all widths fixed (16-bit instruction, 3-bit register index).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- reset_n  in  1  async active-low reset
- s  in  1  start; execute the instruction held in IR
- load  in  1  capture in into IR
- in  in  16  instruction word
- w  out  1  1 = idle in WAIT and ready for s
- readnum, writenum  out  3  register-file read/write index
- vsel  out  2  write-back source: 00 ALU result (C), 10 sximm8
- loada, loadb, loadc, loads, write  out  1  datapath strobes
- asel, bsel  out  1  A-input zero select; B-input immediate select
- shift  out  2  shifter op
- ALUop  out  2  ALU op
- sximm8, sximm5  out  16  sign-extended immediates

Function
REQ-005 IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-006 sximm8 SHALL equal IR[7:0] sign-extended; sximm5 SHALL equal IR[4:0] sign-extended; both combinational from IR.
REQ-007 shift SHALL equal sh in every state; bsel SHALL be 0 in every state.
REQ-008 IR SHALL capture in on the rising edge when load=1 and the state is WAIT; load in any other state SHALL be ignored.
REQ-009 States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG; encoding is implementer's choice.
REQ-010 Outputs SHALL be Moore (state plus IR only); any strobe not listed for a state SHALL be 0; readnum/writenum default 0; vsel defaults 00; asel defaults 0; ALUop defaults 00.
REQ-011 WAIT: w=1; s=1 -> DECODE; else stay. w=0 in all other states.
REQ-012 DECODE routing:
- opcode 110, op 10 (MOV imm) -> WRITE_IMM
- opcode 110, op 00 (MOV reg) or opcode 101, op 11 (MVN) -> GET_B
- opcode 101, op 00/01/10 (ADD/CMP/AND) -> GET_A
- any other encoding -> WAIT, with no strobe asserted.
REQ-013 WRITE_IMM: writenum=Rn, vsel=10, write=1; -> WAIT.
REQ-014 GET_A: readnum=Rn, loada=1; -> GET_B.
REQ-015 GET_B: readnum=Rm, loadb=1; -> ALU.
REQ-016 ALU state by instruction:
- MOV reg: asel=1, ALUop=00, loadc=1
- ADD/AND: asel=0, ALUop=op, loadc=1
- MVN: asel=1, ALUop=11, loadc=1
- CMP: asel=0, ALUop=01, loads=1, loadc=0
REQ-017 Transition out of ALU: CMP -> WAIT; all others -> WRITE_REG.
REQ-018 WRITE_REG: writenum=Rd, vsel=00, write=1; -> WAIT.
REQ-019 Latency (s-sampling edge to w=1):
- invalid: 2 cycles
- MOV imm: 3 cycles
- MOV reg/MVN: 5 cycles
- CMP: 5 cycles
- ADD/AND: 6 cycles
REQ-020 If s is still 1 on the edge w returns to 1, the next edge SHALL start execution again from the current IR.
REQ-021 s SHALL be ignored outside WAIT.
REQ-022 At most one of write/loada/loadb/loadc/loads SHALL be 1 in any cycle.

Reset
REQ-023 reset_n=0 SHALL immediately force:
- state=WAIT, IR=0, w=1
- all strobes 0, readnum=writenum=0, vsel=00, ALUop=00, asel=0
REQ-024 Reset asserted mid-instruction SHALL abort with no further write; the first clock after deassertion is evaluated from WAIT.

Verification
REQ-025 Load 0xD105 (MOV R1,#5), pulse s -> DECODE, then WRITE_IMM with writenum=1, vsel=10, write=1, sximm8=0x0005; w=1 three cycles after s.
REQ-026 Load 0xD2FF -> sximm8=0xFFFF; execute -> write to R2 with vsel=10.
REQ-027 Load 0xA2C9 (ADD R6,R2,R1 LSL#1), s -> in successive cycles:
- loada with readnum=2
- loadb with readnum=1, shift=01
- loadc with ALUop=00, asel=0
- write with writenum=6, vsel=00
- w=1 at cycle 6
REQ-028 Load 0xA9 00|Rm (CMP R1,R0 = 0xA900) -> loads=1 in ALU, loadc=0, no write cycle; w=1 at cycle 5.
REQ-029 Load 0xB8E3 (MVN R7,R3) -> GET_B readnum=3, ALU asel=1/ALUop=11, write writenum=7; invalid 0x0000 -> no strobes, WAIT after 2 cycles.
REQ-030 Assert reset_n=0 during GET_B of an ADD -> same-cycle w=1, all strobes 0, IR=0; no write afterwards; load/s while not in WAIT leave IR and state untouched.

Source files
------------

// File: rtl/cpu_ctrl.sv
// Controller FSM and instruction register for the register-file/ALU datapath.
// Outputs are Moore: they depend only on the current state and the held instruction.
//
// state       | meaning
// WAIT        | idle, w=1, IR loadable, s starts execution
// DECODE      | classify IR and route
// WRITE_IMM   | write sximm8 into Rn
// GET_A       | read Rn into A
// GET_B       | read Rm into B
// ALU         | compute into C, or update status for CMP
// WRITE_REG   | write C into Rd
module cpu_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic       is_mov_imm, is_mov_reg, is_mvn, is_alu3, is_cmp;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    assign is_alu3    = (opcode == 3'b101) && (op != 2'b11);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign shift  = ir[4:3];
    assign bsel   = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (load && (state == S_WAIT))
                ir <= in;
        end
    end

    always_comb begin
        state_nxt = state;
        w         = 1'b0;
        readnum   = 3'd0;
        writenum  = 3'd0;
        vsel      = 2'b00;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        asel      = 1'b0;
        ALUop     = 2'b00;
        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s)
                    state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)
                    state_nxt = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn)
                    state_nxt = S_GET_B;
                else if (is_alu3)
                    state_nxt = S_GET_A;
                else
                    state_nxt = S_WAIT;
            end
            S_WRITE_IMM: begin
                writenum  = rn;
                vsel      = 2'b10;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_GET_A: begin
                readnum   = rn;
                loada     = 1'b1;
                state_nxt = S_GET_B;
            end
            S_GET_B: begin
                readnum   = rm;
                loadb     = 1'b1;
                state_nxt = S_ALU;
            end
            S_ALU: begin
                // MOV/MVN pass B through with A forced to zero
                if (is_mov_reg) begin
                    asel  = 1'b1;
                    ALUop = 2'b00;
                    loadc = 1'b1;
                end else if (is_mvn) begin
                    asel  = 1'b1;
                    ALUop = 2'b11;
                    loadc = 1'b1;
                end else if (is_cmp) begin
                    ALUop = 2'b01;
                    loads = 1'b1;
                end else begin
                    ALUop = op;
                    loadc = 1'b1;
                end
                state_nxt = is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                writenum  = rd;
                vsel      = 2'b00;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: directed and random instructions compared cycle by cycle
// against a per-instruction expected output sequence built from the instruction set rules.
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s;
    logic        load;
    logic [15:0] in_w;
    logic        w;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel;
    logic        loada, loadb, loadc, loads, write, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm8, sximm5;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [1:0]  vsel;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        write;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  ALUop;
        logic [15:0] sximm8;
        logic [15:0] sximm5;
    } out_t;

    out_t exp_q[$];

    cpu_ctrl dut (
        .clk(clk), .reset_n(reset_n), .s(s), .load(load), .in(in_w),
        .w(w), .readnum(readnum), .writenum(writenum), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    // Outputs common to every state for a given instruction: immediates and shift.
    function automatic out_t idle_of(input logic [15:0] ir);
        out_t o;
        int   v;
        o = '0;
        o.shift = ir[4:3];
        v = int'(ir[7:0]);
        if (v >= 128) v = v - 256;
        o.sximm8 = v[15:0];
        v = int'(ir[4:0]);
        if (v >= 16) v = v - 32;
        o.sximm5 = v[15:0];
        return o;
    endfunction

    function automatic out_t wait_of(input logic [15:0] ir);
        out_t o;
        o = idle_of(ir);
        o.w = 1'b1;
        return o;
    endfunction

    // Expected outputs after each clock edge, from the s-sampling edge until back in WAIT.
    function automatic void build(input logic [15:0] ir);
        out_t b, t;
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] opx;
        opc = ir[15:13]; opx = ir[12:11];
        rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0];
        b = idle_of(ir);
        exp_q.delete();
        exp_q.push_back(b);
        if (opc == 3'b110 && opx == 2'b10) begin
            t = b; t.write = 1'b1; t.writenum = rn; t.vsel = 2'b10; exp_q.push_back(t);
        end else if ((opc == 3'b110 && opx == 2'b00) || (opc == 3'b101 && opx == 2'b11)) begin
            t = b; t.loadb = 1'b1; t.readnum = rm; exp_q.push_back(t);
            t = b; t.loadc = 1'b1; t.asel = 1'b1; t.ALUop = (opc == 3'b101) ? 2'b11 : 2'b00;
            exp_q.push_back(t);
            t = b; t.write = 1'b1; t.writenum = rd; exp_q.push_back(t);
        end else if (opc == 3'b101) begin
            t = b; t.loada = 1'b1; t.readnum = rn; exp_q.push_back(t);
            t = b; t.loadb = 1'b1; t.readnum = rm; exp_q.push_back(t);
            if (opx == 2'b01) begin
                t = b; t.loads = 1'b1; t.ALUop = 2'b01; exp_q.push_back(t);
            end else begin
                t = b; t.loadc = 1'b1; t.ALUop = opx; exp_q.push_back(t);
                t = b; t.write = 1'b1; t.writenum = rd; exp_q.push_back(t);
            end
        end
        exp_q.push_back(wait_of(ir));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input out_t e);
        out_t o;
        o = '{w, readnum, writenum, vsel, loada, loadb, loadc, loads, write,
              asel, bsel, shift, ALUop, sximm8, sximm5};
        vectors++;
        assert (o === e)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Load instr, pulse s, and follow the whole execution; hold=1 keeps s high to re-run it.
    task automatic exec(input logic [15:0] instr, input bit hold, input string tag);
        int reps;
        load = 1'b1; in_w = instr; s = 1'b0;
        tick;
        check({tag, "/load"}, wait_of(instr));
        build(instr);
        load = 1'b0; s = 1'b1;
        reps = hold ? 2 : 1;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tick;
                check($sformatf("%s/r%0d/c%0d", tag, r, i + 1), exp_q[i]);
                if (i < exp_q.size() - 1) begin
                    s    = 1'($urandom);
                    load = 1'($urandom);
                    in_w = 16'($urandom);
                end else begin
                    load = 1'b0;
                    s    = hold && (r == 0);
                end
            end
        end
        s = 1'b0;
    endtask

    initial begin
        logic [15:0] instr;
        reset_n = 1'b0; s = 1'b0; load = 1'b0; in_w = 16'h0000;
        #2;
        check("reset", wait_of(16'h0000));
        @(negedge clk);
        reset_n = 1'b1;

        exec(16'hD105, 1'b0, "mov_imm5");
        exec(16'hD2FF, 1'b0, "mov_imm_neg");
        exec(16'hA2C9, 1'b0, "add_lsl");
        exec(16'hA900, 1'b0, "cmp");
        exec(16'hB8E3, 1'b0, "mvn");
        exec(16'h0000, 1'b0, "invalid");
        exec(16'hC0A6, 1'b0, "mov_reg");
        exec(16'hB45B, 1'b0, "and");
        exec(16'hD105, 1'b1, "restart");

        // s held low in WAIT must not start anything
        load = 1'b1; in_w = 16'hA2C9; s = 1'b0;
        tick;
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check($sformatf("idle/%0d", i), wait_of(16'hA2C9));
        end

        // Reset during GET_B of an ADD aborts immediately
        s = 1'b1;
        tick;
        s = 1'b0;
        tick;
        tick;
        build(16'hA2C9);
        check("pre_reset_get_b", exp_q[2]);
        reset_n = 1'b0;
        #1;
        check("reset_mid", wait_of(16'h0000));
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check($sformatf("post_reset/%0d", i), wait_of(16'h0000));
        end

        for (int n = 0; n < 200; n++) begin
            instr = 16'($urandom);
            case ($urandom_range(0, 6))
                0: instr[15:11] = 5'b11010;
                1: instr[15:11] = 5'b11000;
                2: instr[15:11] = 5'b10111;
                3: instr[15:11] = 5'b10100;
                4: instr[15:11] = 5'b10101;
                5: instr[15:11] = 5'b10110;
                default: ;
            endcase
            exec(instr, ($urandom_range(0, 9) == 0), $sformatf("rnd%0d_%h", n, instr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
